// File: rtl/xtal_clock_monitor.sv
// Crystal oscillator controller and frequency qualifier.
// Enables the oscillator, waits for it to start up, then counts synchronized
// xtal_clk rising edges over fixed windows of the system clock. The crystal is
// declared good after enough consecutive in-range windows and failed if it
// cannot qualify within a bounded number of windows.
module xtal_clock_monitor #(
  parameter int CNT_W          = 16,
  parameter int WINDOW_CYCLES  = 1024,
  parameter int EXP_MIN        = 240,
  parameter int EXP_MAX        = 272,
  parameter int STARTUP_CYCLES = 4096,
  parameter int GOOD_WINDOWS   = 4,
  parameter int MAX_WINDOWS    = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             xtal_clk,
  output logic             xtal_en,
  output logic             clk_good,
  output logic             clk_fail,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic [2:0]       state
);

  localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int STUP_W = $clog2(STARTUP_CYCLES + 1);
  localparam int GR_W   = $clog2(GOOD_WINDOWS + 1);
  localparam int TR_W   = $clog2(MAX_WINDOWS + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [STUP_W-1:0] STUP_LAST = STUP_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  EXP_MIN_C = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  EXP_MAX_C = CNT_W'(EXP_MAX);
  localparam logic [GR_W-1:0]   GOOD_C    = GR_W'(GOOD_WINDOWS);
  localparam logic [TR_W-1:0]   MAX_C     = TR_W'(MAX_WINDOWS);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    STARTUP = 3'd1,
    MEASURE = 3'd2,
    GOOD    = 3'd3,
    FAIL    = 3'd4
  } state_t;

  state_t            state_q;
  logic              sync1;
  logic              sync2;
  logic              sync3;
  logic              xtal_edge;
  logic [CNT_W-1:0]  acc;
  logic [WIN_W-1:0]  win_cnt;
  logic [STUP_W-1:0] startup_cnt;
  logic [GR_W-1:0]   good_run;
  logic [TR_W-1:0]   tries;

  logic              measuring;
  logic              win_end;
  logic              startup_done;
  logic              sum_carry;
  logic [CNT_W-1:0]  sum;
  logic [CNT_W-1:0]  window_total;
  logic              in_range;
  logic [GR_W-1:0]   good_run_next;
  logic [TR_W-1:0]   tries_next;

  assign state = state_q;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= xtal_clk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Window bookkeeping: saturating total, range test and next run/try counts.
  always_comb begin
    xtal_edge     = sync2 & ~sync3;
    measuring     = (state_q == MEASURE) || (state_q == GOOD);
    win_end       = enable && measuring && (win_cnt == WIN_LAST);
    startup_done  = (startup_cnt == STUP_LAST);
    {sum_carry, sum} = {1'b0, acc} + {{CNT_W{1'b0}}, xtal_edge};
    window_total  = sum_carry ? {CNT_W{1'b1}} : sum;
    in_range      = (window_total >= EXP_MIN_C) && (window_total <= EXP_MAX_C);
    good_run_next = in_range ? (good_run + GR_W'(1)) : '0;
    tries_next    = tries + TR_W'(1);
  end

  // Window cycle counter, only running while the crystal is being measured.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      win_cnt <= '0;
    end else if (enable && measuring) begin
      win_cnt <= win_end ? '0 : (win_cnt + WIN_W'(1));
    end else begin
      win_cnt <= '0;
    end
  end

  // Edge accumulator; any partial window is dropped when measuring stops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= '0;
    end else if (enable && measuring) begin
      acc <= win_end ? '0 : window_total;
    end else begin
      acc <= '0;
    end
  end

  // Publish the completed window count with a one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      edge_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= win_end;
      if (win_end) begin
        edge_count <= window_total;
      end
    end
  end

  // Startup timer, restarted on every entry into STARTUP.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      startup_cnt <= '0;
    end else if (enable && (state_q == STARTUP)) begin
      startup_cnt <= startup_done ? '0 : (startup_cnt + STUP_W'(1));
    end else begin
      startup_cnt <= '0;
    end
  end

  // Control FSM; outputs are registered alongside each state transition.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= OFF;
      xtal_en  <= 1'b0;
      clk_good <= 1'b0;
      clk_fail <= 1'b0;
      good_run <= '0;
      tries    <= '0;
    end else if (!enable) begin
      state_q  <= OFF;
      xtal_en  <= 1'b0;
      clk_good <= 1'b0;
      clk_fail <= 1'b0;
      good_run <= '0;
      tries    <= '0;
    end else begin
      case (state_q)
        OFF: begin
          state_q  <= STARTUP;
          xtal_en  <= 1'b1;
          clk_good <= 1'b0;
          clk_fail <= 1'b0;
        end
        STARTUP: begin
          if (startup_done) begin
            state_q  <= MEASURE;
            good_run <= '0;
            tries    <= '0;
          end
        end
        MEASURE: begin
          if (win_end) begin
            good_run <= good_run_next;
            tries    <= tries_next;
            if (good_run_next >= GOOD_C) begin
              state_q  <= GOOD;
              clk_good <= 1'b1;
            end else if (tries_next >= MAX_C) begin
              state_q  <= FAIL;
              xtal_en  <= 1'b0;
              clk_fail <= 1'b1;
            end
          end
        end
        GOOD: begin
          if (win_end && !in_range) begin
            state_q  <= MEASURE;
            clk_good <= 1'b0;
            good_run <= '0;
            tries    <= '0;
          end
        end
        FAIL: begin
          state_q <= FAIL;
        end
        default: begin
          state_q  <= OFF;
          xtal_en  <= 1'b0;
          clk_good <= 1'b0;
          clk_fail <= 1'b0;
          good_run <= '0;
          tries    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xtal_clock_monitor.sv
// Directed testbench for xtal_clock_monitor with small window parameters.
// Time unit is treated as 0.1ns: clk period 100 units, xtal generator ticks
// every 10 units offset by 5 so xtal edges never coincide with clk edges.
module tb_xtal_clock_monitor;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             enable = 1'b0;
  logic             xtal_clk = 1'b0;
  logic             xtal_en;
  logic             clk_good;
  logic             clk_fail;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic [2:0]       state;

  int xtalHalf = 0;
  int xtalPhase = 0;
  int testsRun = 0;
  int testsFailed = 0;

  xtal_clock_monitor #(
    .CNT_W(CNT_W),
    .WINDOW_CYCLES(64),
    .EXP_MIN(14),
    .EXP_MAX(18),
    .STARTUP_CYCLES(32),
    .GOOD_WINDOWS(2),
    .MAX_WINDOWS(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .xtal_clk(xtal_clk),
    .xtal_en(xtal_en),
    .clk_good(clk_good),
    .clk_fail(clk_fail),
    .edge_count(edge_count),
    .count_valid(count_valid),
    .state(state)
  );

  // 10ns system clock
  always #50 clk = ~clk;

  // Crystal model: half period in 1ns ticks, zero holds the line low
  initial begin
    #5;
    forever begin
      #10;
      if (xtalHalf == 0) begin
        xtal_clk = 1'b0;
        xtalPhase = 0;
      end else begin
        xtalPhase++;
        if (xtalPhase >= xtalHalf) begin
          xtalPhase = 0;
          xtal_clk = ~xtal_clk;
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rstn, input int half);
    enable = en;
    resetn = rstn;
    xtalHalf = half;
  endtask

  task automatic waitForValid(input string tag, input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!count_valid && waited < budget);
    if (!count_valid) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Called right after enable=1/resetn=1 are applied at a negedge from OFF
  task automatic runStartup(input string tag);
    @(negedge clk);
    checkOutput({tag, "_startup_state"}, 32'(state), 32'd1);
    checkOutput({tag, "_startup_xtal_en"}, 32'(xtal_en), 32'd1);
    repeat (31) @(negedge clk);
    checkOutput({tag, "_still_startup"}, 32'(state), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_measure_state"}, 32'(state), 32'd2);
  endtask

  initial begin
    int waited;
    int valids;
    logic inRange;

    // Test 1: reset with enable held high
    applyStimulus(1'b1, 1'b0, 20);
    repeat (5) @(negedge clk);
    checkOutput("t1_rst_state", 32'(state), 32'd0);
    checkOutput("t1_rst_xtal_en", 32'(xtal_en), 32'd0);
    checkOutput("t1_rst_good", 32'(clk_good), 32'd0);
    checkOutput("t1_rst_fail", 32'(clk_fail), 32'd0);
    checkOutput("t1_rst_valid", 32'(count_valid), 32'd0);
    checkOutput("t1_rst_count", 32'(edge_count), 32'd0);
    applyStimulus(1'b1, 1'b1, 20);
    runStartup("t1");

    // Test 2: 40ns crystal, 16 edges per window, good at 2nd window
    waitForValid("t2_w1", 100, waited);
    checkOutput("t2_w1_latency", 32'(waited), 32'd64);
    checkOutput("t2_w1_count", 32'(edge_count), 32'd16);
    checkOutput("t2_w1_good", 32'(clk_good), 32'd0);
    checkOutput("t2_w1_state", 32'(state), 32'd2);
    waitForValid("t2_w2", 100, waited);
    checkOutput("t2_w2_latency", 32'(waited), 32'd64);
    checkOutput("t2_w2_count", 32'(edge_count), 32'd16);
    checkOutput("t2_w2_good", 32'(clk_good), 32'd1);
    checkOutput("t2_w2_state", 32'(state), 32'd3);
    @(negedge clk);
    checkOutput("t2_valid_pulse", 32'(count_valid), 32'd0);

    // Test 3: stop the crystal late in a window so the next window is empty
    repeat (60) @(negedge clk);
    xtalHalf = 0;
    waitForValid("t3_w1", 100, waited);
    checkOutput("t3_w1_state", 32'(state), 32'd3);
    checkOutput("t3_w1_good", 32'(clk_good), 32'd1);
    waitForValid("t3_w2", 100, waited);
    checkOutput("t3_w2_count", 32'(edge_count), 32'd0);
    checkOutput("t3_w2_good", 32'(clk_good), 32'd0);
    checkOutput("t3_w2_state", 32'(state), 32'd2);
    xtalHalf = 20;
    waitForValid("t3_w3", 100, waited);
    checkOutput("t3_w3_state", 32'(state), 32'd2);
    waitForValid("t3_w4", 100, waited);
    checkOutput("t3_w4_count", 32'(edge_count), 32'd16);
    checkOutput("t3_w4_state", 32'(state), 32'd3);
    checkOutput("t3_w4_good", 32'(clk_good), 32'd1);

    // Test 4: 30ns crystal is too fast, leave GOOD then fail after 8 windows
    xtalHalf = 15;
    waitForValid("t4_w0", 100, waited);
    checkOutput("t4_w0_state", 32'(state), 32'd2);
    checkOutput("t4_w0_good", 32'(clk_good), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      waitForValid("t4_win", 100, waited);
      checkOutput("t4_count_21_22", 32'((edge_count == 16'd21) || (edge_count == 16'd22)), 32'd1);
      checkOutput("t4_state", 32'(state), (i < 8) ? 32'd2 : 32'd4);
      checkOutput("t4_fail", 32'(clk_fail), (i < 8) ? 32'd0 : 32'd1);
      checkOutput("t4_xtal_en", 32'(xtal_en), (i < 8) ? 32'd1 : 32'd0);
    end
    repeat (80) @(negedge clk);
    checkOutput("t4_fail_held", 32'(clk_fail), 32'd1);
    applyStimulus(1'b0, 1'b1, 15);
    @(negedge clk);
    checkOutput("t4_off_state", 32'(state), 32'd0);
    checkOutput("t4_off_fail", 32'(clk_fail), 32'd0);

    // Test 5: alternating in-range / out-of-range windows never qualify
    applyStimulus(1'b1, 1'b1, 20);
    runStartup("t5");
    for (int i = 1; i <= 8; i++) begin
      waitForValid("t5_win", 100, waited);
      inRange = (edge_count >= 16'd14) && (edge_count <= 16'd18);
      checkOutput("t5_in_range", 32'(inRange), ((i % 2) == 1) ? 32'd1 : 32'd0);
      checkOutput("t5_good", 32'(clk_good), 32'd0);
      checkOutput("t5_state", 32'(state), (i < 8) ? 32'd2 : 32'd4);
      xtalHalf = ((i % 2) == 1) ? 30 : 20;
    end
    checkOutput("t5_fail", 32'(clk_fail), 32'd1);

    // Test 6a: enable drop mid-window in GOOD discards the partial window
    applyStimulus(1'b0, 1'b1, 20);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 20);
    runStartup("t6");
    waitForValid("t6_w1", 100, waited);
    waitForValid("t6_w2", 100, waited);
    checkOutput("t6_good_state", 32'(state), 32'd3);
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 20);
    @(negedge clk);
    checkOutput("t6_off_state", 32'(state), 32'd0);
    checkOutput("t6_off_good", 32'(clk_good), 32'd0);
    checkOutput("t6_off_xtal_en", 32'(xtal_en), 32'd0);
    valids = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (count_valid) valids++;
    end
    checkOutput("t6_no_valid", 32'(valids), 32'd0);
    checkOutput("t6_count_kept", 32'(edge_count), 32'd16);

    // Test 6b: reset mid-STARTUP returns to OFF and clears the timer
    applyStimulus(1'b1, 1'b1, 20);
    repeat (10) @(negedge clk);
    checkOutput("t6b_in_startup", 32'(state), 32'd1);
    applyStimulus(1'b1, 1'b0, 20);
    @(negedge clk);
    checkOutput("t6b_rst_state", 32'(state), 32'd0);
    checkOutput("t6b_rst_xtal_en", 32'(xtal_en), 32'd0);
    checkOutput("t6b_rst_count", 32'(edge_count), 32'd0);
    applyStimulus(1'b1, 1'b1, 20);
    runStartup("t6b");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
